ddr3_axi_resp_model: RTL
========================

# ddr3_axi_resp_model

- Synthesizable responder for the DDR3 controller user-side AXI-like port: AW/W/AR/R channels with `awready`/`wready`/`arready` and a master-paced `rvalid`.
- Backs the port with on-chip RAM, so master-side traffic generators and checkers can run on a board or in simulation without the DDR3 IP or memory devices.
- Also emulates `ddr_init_done` sequencing after reset.

## Interface
- `ADDR_W`, 28: address width, in 32-bit word units; one 256-bit beat spans 8 units.
- `DATA_W`, 256: beat width; `DATA_W/8` strobe bits.
- `MEM_AW`, 8: log2 of RAM depth in beats; default 256 beats.
- `INIT_CYCLES`, 64: `core_clk` cycles from reset release to `ddr_init_done`.

Ports:
- `core_clk`  in  1  clock; all logic is rising-edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `ddr_init_done`  out  1  high once init completes.
- `axi_awaddr`  in  ADDR_W  write burst start address.
- `axi_awuser_id`  in  4  write ID.
- `axi_awlen`  in  4  beats minus 1.
- `axi_awvalid`  in  1  write request valid.
- `axi_awready`  out  1  write request accept.
- `axi_wdata`  in  DATA_W  write beat data; sampled on cycles with `wready`=1.
- `axi_wstrb`  in  DATA_W/8  byte enables.
- `axi_wready`  out  1  write beat taken this cycle.
- `axi_wusero_id`  out  4  ID of the current write burst.
- `axi_wusero_last`  out  1  final write beat.
- `axi_araddr`  in  ADDR_W  read burst start address.
- `axi_aruser_id`  in  4  read ID.
- `axi_arlen`  in  4  beats minus 1.
- `axi_arvalid`  in  1  read request valid.
- `axi_arready`  out  1  read request accept.
- `axi_rdata`  out  DATA_W  read beat data.
- `axi_rid`  out  4  read ID.
- `axi_rlast`  out  1  final read beat.
- `axi_rvalid`  out  1  read beat valid; no back-pressure from the master.

## Operation
- **Reset values:** all outputs 0 and state INIT. The init counter clears. RAM contents are retained across reset and undefined at power-up.
- **INIT:** counts `INIT_CYCLES` cycles, then moves to IDLE and sets `ddr_init_done`=1, which holds until reset. `awready`/`arready` are held at 0 in INIT.
- **IDLE:** `awready` and `arready` are combinational.
  - `awready` = IDLE & (~arvalid | pref_wr).
  - `arready` = IDLE & (~awvalid | ~pref_wr).
  - `pref_wr` resets to 1 and toggles on every granted handshake when both valids were high (round-robin). A lone request is granted immediately.
- **Request capture:** on handshake, latch beat address `addr[ADDR_W-1:3]`, length `len+1`, and ID. Go to WR or RD.
- **WR:**
  - `wready`=1 for each beat.
  - RAM[beat_addr mod 2^MEM_AW] bytes with `wstrb`=1 are updated from `wdata`; then beat_addr increments.
  - `wusero_last`=1 together with the final `wready`. `wusero_id` = captured ID throughout WR.
  - After the final beat, return to IDLE.
- **RD:** the RAM read is pipelined by one register stage. `rvalid` beats carry RAM[beat_addr mod 2^MEM_AW]. `rlast` marks beat `len+1`; `rid` = captured ID. After the final beat, return to IDLE.
- **Address wrap:** beat_addr wraps modulo 2^MEM_AW silently, including mid-burst. Upper address bits alias. `addr[2:0]` is ignored.
- **Busy:** no new AW or AR is accepted until the current burst completes. There is no outstanding-request queue.
- **Reset mid-burst:** the burst is abandoned and all outputs drop to 0 asynchronously. The init sequence reruns. RAM writes already completed persist.

## Timing
- Reset release at cycle 0 gives `ddr_init_done`=1 at cycle `INIT_CYCLES`.
- **Write:** AW handshake at cycle T.
  - `wready`=1 on cycles T+1 .. T+len+1.
  - `wusero_last` on T+len+1.
  - IDLE with `awready` able to assert on T+len+2.
- **Read:** AR handshake at cycle T.
  - `rvalid`=1 on cycles T+2 .. T+len+2.
  - `rlast` on T+len+2.
  - IDLE on T+len+3.
- **Read-after-write:** a read accepted the cycle after a write's last beat returns the new data.
- `rdata`/`rid`/`rlast` hold their last values when `rvalid`=0.

## Configuration
- `DDR_MODEL_BP_EN` defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5; advances every cycle in WR/RD) inserts stalls.
  - In any WR/RD cycle where lfsr[0]=0, that beat is withheld (`wready`/`rvalid`=0) and the beat counter holds.
  - Latencies above become minimums.
- Undefined: beats are contiguous, exactly as in Timing.

## Test plan
- **Init:** reset release -> `ddr_init_done` rises at exactly cycle 64; AW/AR offered earlier see `awready`/`arready`=0.
- **Write/read-back:** write 16 beats (awlen=15, addr 0) with data k for beat k, then read addr 0 -> `rvalid` on T+2..T+17, `rdata`=0..15, `rlast` on beat 16, `rid` echoes `aruser_id`=4'h5.
- **Tie arbitration:** awvalid and arvalid both high in IDLE twice in a row -> first grant write, second grant read.
- **Wrap:** write 4 beats at addr 28'h7F8 (beat 255) with MEM_AW=8 -> beats land at RAM 255,0,1,2; reading addr 0 returns beat 2 of that burst first.
- **Partial strobe:** wstrb=32'h0000_000F over all-ones data, after prior all-zeros fill -> read-back data = 256'hFFFF_FFFF in bits [31:0], zeros elsewhere.
- **Mid-burst reset:** assert `i_rst_n`=0 at beat 8 of a 16-beat write -> all outputs 0 the same cycle, `ddr_init_done` re-asserts 64 cycles after release, and beats 0..7 read back intact.

Source files
------------

// File: rtl/ddr3_axi_resp_model.sv
// On-chip RAM responder for the DDR3 controller user-side AXI-like port, with init emulation.
// Define DDR_MODEL_BP_EN to insert LFSR-driven beat stalls in WR/RD.
`timescale 1ns/1ps
module ddr3_axi_resp_model #(
  parameter int unsigned ADDR_W      = 28,
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned MEM_AW      = 8,
  parameter int unsigned INIT_CYCLES = 64
) (
  input  logic                core_clk,
  input  logic                i_rst_n,
  output logic                ddr_init_done,
  input  logic [ADDR_W-1:0]   axi_awaddr,
  input  logic [3:0]          axi_awuser_id,
  input  logic [3:0]          axi_awlen,
  input  logic                axi_awvalid,
  output logic                axi_awready,
  input  logic [DATA_W-1:0]   axi_wdata,
  input  logic [DATA_W/8-1:0] axi_wstrb,
  output logic                axi_wready,
  output logic [3:0]          axi_wusero_id,
  output logic                axi_wusero_last,
  input  logic [ADDR_W-1:0]   axi_araddr,
  input  logic [3:0]          axi_aruser_id,
  input  logic [3:0]          axi_arlen,
  input  logic                axi_arvalid,
  output logic                axi_arready,
  output logic [DATA_W-1:0]   axi_rdata,
  output logic [3:0]          axi_rid,
  output logic                axi_rlast,
  output logic                axi_rvalid
);

  localparam int unsigned StrbW    = DATA_W / 8;
  localparam int unsigned InitCntW = $clog2(INIT_CYCLES + 1);

  typedef enum logic [1:0] {StInit, StIdle, StWr, StRd} state_e;

  state_e              state_q;
  logic [InitCntW-1:0] init_cnt_q;
  logic [MEM_AW-1:0]   beat_addr_q;
  logic [4:0]          rem_q;
  logic [3:0]          id_q;
  logic                pref_wr_q;
  logic                done_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic [3:0]          rid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [DATA_W-1:0]   mem_q [2**MEM_AW];

  logic beat_en;
  logic aw_hs;
  logic ar_hs;
  logic rd_issue;
  logic unused_addr;

`ifdef DDR_MODEL_BP_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge core_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lfsr_q <= 8'hA5;
    end else if (state_q == StWr || state_q == StRd) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign beat_en = lfsr_q[0];
`else
  assign beat_en = 1'b1;
`endif

  // Round-robin only matters when both valids are high; a lone request always wins.
  assign axi_awready = (state_q == StIdle) && (!axi_arvalid || pref_wr_q);
  assign axi_arready = (state_q == StIdle) && (!axi_awvalid || !pref_wr_q);
  assign aw_hs       = axi_awvalid && axi_awready;
  assign ar_hs       = axi_arvalid && axi_arready;

  assign axi_wready      = (state_q == StWr) && beat_en;
  assign axi_wusero_last = axi_wready && (rem_q == 5'd1);
  assign axi_wusero_id   = (state_q == StWr) ? id_q : 4'h0;
  assign rd_issue        = (state_q == StRd) && (rem_q != 5'd0) && beat_en;

  assign ddr_init_done = done_q;
  assign axi_rvalid    = rvalid_q;
  assign axi_rdata     = rdata_q;
  assign axi_rid       = rid_q;
  assign axi_rlast     = rlast_q;

  // Word offset and bits above the RAM depth alias by design.
  assign unused_addr = ^{axi_awaddr, axi_araddr};

  always_ff @(posedge core_clk) begin
    if (axi_wready) begin
      for (int unsigned b = 0; b < StrbW; b++) begin
        if (axi_wstrb[b]) begin
          mem_q[beat_addr_q][b*8 +: 8] <= axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge core_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StInit;
      init_cnt_q  <= '0;
      beat_addr_q <= '0;
      rem_q       <= '0;
      id_q        <= '0;
      pref_wr_q   <= 1'b1;
      done_q      <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rid_q       <= '0;
      rlast_q     <= 1'b0;
    end else begin
      rvalid_q <= rd_issue;
      if (rd_issue) begin
        rdata_q <= mem_q[beat_addr_q];
        rid_q   <= id_q;
        rlast_q <= (rem_q == 5'd1);
      end
      if ((aw_hs || ar_hs) && axi_awvalid && axi_arvalid) begin
        pref_wr_q <= !pref_wr_q;
      end
      if (axi_wready || rd_issue) begin
        beat_addr_q <= beat_addr_q + MEM_AW'(1);
        rem_q       <= rem_q - 5'd1;
      end
      case (state_q)
        StInit: begin
          if (init_cnt_q == InitCntW'(INIT_CYCLES - 1)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + InitCntW'(1);
          end
        end
        StIdle: begin
          if (aw_hs) begin
            beat_addr_q <= axi_awaddr[MEM_AW+2:3];
            rem_q       <= {1'b0, axi_awlen} + 5'd1;
            id_q        <= axi_awuser_id;
            state_q     <= StWr;
          end else if (ar_hs) begin
            beat_addr_q <= axi_araddr[MEM_AW+2:3];
            rem_q       <= {1'b0, axi_arlen} + 5'd1;
            id_q        <= axi_aruser_id;
            state_q     <= StRd;
          end
        end
        StWr: begin
          if (axi_wready && rem_q == 5'd1) state_q <= StIdle;
        end
        StRd: begin
          // Stay until the registered last beat has been presented.
          if (rvalid_q && rlast_q) state_q <= StIdle;
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule
